// File: rtl/aud_pkg.sv
// Shared types and constants for the audio DAC serializer path.
package aud_pkg;

    typedef enum logic {
        AUD_I2S = 1'b0,
        AUD_LJ  = 1'b1
    } aud_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } aud_state_e;

    localparam int unsigned AUD_SYNC_MIN = 2;

endpackage

// File: rtl/aud_clk_sync.sv
// Brings the codec bclk/lrck into the system clock domain and flags bclk falling edges.
module aud_clk_sync
    import aud_pkg::*;
#(
    parameter int unsigned STAGES = AUD_SYNC_MIN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bclk_i,
    input  logic lrck_i,
    output logic bclk_fall_c_o,
    output logic lrck_sampled_o
);

    localparam int unsigned N = (STAGES < AUD_SYNC_MIN) ? AUD_SYNC_MIN : STAGES;

    logic [N-1:0] bclk_sync_q;
    logic [N-1:0] lrck_sync_q;
    logic         bclk_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[N-2:0], bclk_i};
            lrck_sync_q <= {lrck_sync_q[N-2:0], lrck_i};
            bclk_prev_q <= bclk_sync_q[N-1];
        end
    end

    assign bclk_fall_c_o  = bclk_prev_q & ~bclk_sync_q[N-1];
    assign lrck_sampled_o = lrck_sync_q[N-1];

endmodule

// File: rtl/aud_player_i2s.sv
// Stereo frame buffer and I2S / left-justified serializer for the codec DAC data line.
module aud_player_i2s
    import aud_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SLOT_MAX    = 32,
    parameter int unsigned MODE        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bclk,
    input  logic              i_daclrck,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    output logic              o_ready,
    output logic              o_aud_dacdat,
    output logic              o_underflow,
    output logic              o_busy
);

    localparam int unsigned CNT_W  = $clog2(SLOT_MAX + 1);
    localparam aud_mode_e   MODE_E = (MODE == 1) ? AUD_LJ : AUD_I2S;

    logic bclk_fall_c;
    logic lrck_s;

    aud_clk_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i          (i_clk),
        .rst_i          (i_rst),
        .bclk_i         (i_bclk),
        .lrck_i         (i_daclrck),
        .bclk_fall_c_o  (bclk_fall_c),
        .lrck_sampled_o (lrck_s)
    );

    aud_state_e        state_q, state_d;
    logic              lrck_prev_q, lrck_prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] left_sr_q, left_sr_d, right_sr_q, right_sr_d;
    logic [DATA_W-1:0] buf_left_q, buf_left_d, buf_right_q, buf_right_d;
    logic              buf_empty_q, buf_empty_d;
    logic              dac_q, dac_d, uf_q, uf_d, busy_q, busy_d;

    logic              lr_edge_c, start_c, accept_c, load_c;
    logic [DATA_W-1:0] new_left_c, word_c, shift_c;
    int unsigned       pos_c;

    always_comb begin
        state_d     = state_q;
        lrck_prev_d = lrck_prev_q;
        cnt_d       = cnt_q;
        left_sr_d   = left_sr_q;
        right_sr_d  = right_sr_q;
        buf_left_d  = buf_left_q;
        buf_right_d = buf_right_q;
        buf_empty_d = buf_empty_q;
        dac_d       = dac_q;
        uf_d        = 1'b0;
        word_c      = '0;
        shift_c     = '0;
        pos_c       = 0;

        lr_edge_c  = bclk_fall_c && (lrck_s != lrck_prev_q);
        start_c    = lr_edge_c && !lrck_s;
        accept_c   = i_valid && buf_empty_q;
        load_c     = start_c && i_en && !buf_empty_q;
        new_left_c = load_c ? buf_left_q : '0;

        case (state_q)
            S_IDLE:  if (start_c) state_d = S_LEFT;
            S_LEFT:  if (lr_edge_c && lrck_s) state_d = S_RIGHT;
            S_RIGHT: if (start_c) state_d = S_LEFT;
            default: state_d = S_IDLE;
        endcase

        // Right data is captured together with left so a frame never splits across buffer entries.
        if (start_c) begin
            right_sr_d = load_c ? buf_right_q : '0;
            uf_d       = i_en && buf_empty_q;
        end

        if (accept_c) begin
            buf_left_d  = i_left;
            buf_right_d = i_right;
            buf_empty_d = 1'b0;
        end else if (load_c) begin
            buf_empty_d = 1'b1;
        end

        if (bclk_fall_c) begin
            lrck_prev_d = lrck_s;
            pos_c       = lr_edge_c ? 0 : 32'(cnt_q);
            cnt_d       = (pos_c >= SLOT_MAX) ? CNT_W'(SLOT_MAX) : CNT_W'(pos_c + 1);
            if (state_q != S_IDLE || start_c) begin
                word_c = start_c ? new_left_c : (lrck_s ? right_sr_q : left_sr_q);
                // I2S spends the lrck-edge slot on a zero before the MSB.
                if (lr_edge_c && MODE_E == AUD_I2S) begin
                    dac_d   = 1'b0;
                    shift_c = word_c;
                end else begin
                    dac_d   = word_c[DATA_W-1] && (pos_c <= DATA_W);
                    shift_c = {word_c[DATA_W-2:0], 1'b0};
                end
                if (lrck_s) right_sr_d = shift_c;
                else        left_sr_d  = shift_c;
            end else begin
                dac_d = 1'b0;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            lrck_prev_q <= 1'b0;
            cnt_q       <= '0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            buf_left_q  <= '0;
            buf_right_q <= '0;
            buf_empty_q <= 1'b1;
            dac_q       <= 1'b0;
            uf_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrck_prev_q <= lrck_prev_d;
            cnt_q       <= cnt_d;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            buf_left_q  <= buf_left_d;
            buf_right_q <= buf_right_d;
            buf_empty_q <= buf_empty_d;
            dac_q       <= dac_d;
            uf_q        <= uf_d;
            busy_q      <= busy_d;
        end
    end

    assign o_ready      = buf_empty_q;
    assign o_aud_dacdat = dac_q;
    assign o_underflow  = uf_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_aud_player_i2s.sv
// Directed bench for aud_player_i2s: an I2S (MODE=0) and a left-justified (MODE=1) instance share stimulus.
module tb_aud_player_i2s;

    logic        clk = 1'b0;
    logic        rst, bclk, lrck, en, valid;
    logic [15:0] left, right;
    logic        ready0, dac0, uf0, busy0;
    logic        ready1, dac1, uf1, busy1;

    int n_vec = 0;
    int n_err = 0;
    int uf_cnt0 = 0;
    int uf_cnt1 = 0;
    int acc_cnt = 0;
    logic ready_n0 = 1'b0;

    logic        cap0[$];
    logic        cap1[$];
    logic [31:0] pq[$];
    logic        rst_dac1, rst_busy1, rst_ready1;

    always #5 clk = ~clk;

    aud_player_i2s #(.DATA_W(16), .SLOT_MAX(32), .MODE(0), .SYNC_STAGES(2)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_daclrck(lrck), .i_en(en),
        .i_valid(valid), .i_left(left), .i_right(right), .o_ready(ready0),
        .o_aud_dacdat(dac0), .o_underflow(uf0), .o_busy(busy0)
    );

    aud_player_i2s #(.DATA_W(16), .SLOT_MAX(32), .MODE(1), .SYNC_STAGES(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_daclrck(lrck), .i_en(en),
        .i_valid(valid), .i_left(left), .i_right(right), .o_ready(ready1),
        .o_aud_dacdat(dac1), .o_underflow(uf1), .o_busy(busy1)
    );

    always @(negedge clk) begin
        ready_n0 <= ready0;
        if (uf0 === 1'b1) uf_cnt0 <= uf_cnt0 + 1;
        if (uf1 === 1'b1) uf_cnt1 <= uf_cnt1 + 1;
    end

    // Frame source: holds valid until the DUT was ready at the preceding edge.
    initial begin : pusher
        logic [31:0] f;
        valid = 1'b0;
        left  = '0;
        right = '0;
        forever begin
            @(posedge clk); #1;
            if (valid && ready_n0) begin
                valid = 1'b0;
                acc_cnt++;
            end
            if (!valid && pq.size() > 0) begin
                f     = pq.pop_front();
                left  = f[31:16];
                right = f[15:0];
                valid = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; bclk = 1'b1; lrck = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
    endtask

    // Codec model: bclk = clk/8, lrck changes on bclk fall; half 0 is a right half.
    task automatic play(input int nhalves, input int len, input int rst_fall, input logic [31:0] post_frame);
        int k;
        k = 0;
        cap0.delete();
        cap1.delete();
        for (int h = 0; h < nhalves; h++) begin
            for (int b = 0; b < len; b++) begin
                bclk = 1'b0;
                if (b == 0) lrck = (h % 2 == 0);
                repeat (3) @(posedge clk); #1;
                cap0.push_back(dac0);
                cap1.push_back(dac1);
                if (k == rst_fall) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst_dac1   = dac1;
                    rst_busy1  = busy1;
                    rst_ready1 = ready1;
                    rst        = 1'b0;
                    pq.push_back(post_frame);
                end else begin
                    @(posedge clk); #1;
                end
                bclk = 1'b1;
                repeat (4) @(posedge clk); #1;
                k++;
            end
        end
    endtask

    function automatic logic [31:0] half_word(input logic which, input int h, input int len);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < len; b++)
            w = {w[30:0], (which ? cap1[h*len+b] : cap0[h*len+b])};
        return w;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bclk = !bclk;
            n_vec++; if (dac0 !== 1'b0)  begin n_err++; $display("FAIL reset_dac0: got %b expected 0", dac0); end
            n_vec++; if (dac1 !== 1'b0)  begin n_err++; $display("FAIL reset_dac1: got %b expected 0", dac1); end
            n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready0); end
            n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy0); end
            n_vec++; if (uf0 !== 1'b0)   begin n_err++; $display("FAIL reset_underflow: got %b expected 0", uf0); end
        end
        rst = 1'b0;
        bclk = 1'b1;
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_i2s();
        logic [31:0] w;
        do_reset();
        en = 1'b1;
        pq.push_back({16'hA5C3, 16'h0F0F});
        repeat (4) @(posedge clk); #1;
        n_vec++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL i2s_ready_full: got %b expected 0", ready0); end
        play(3, 32, -1, 32'h0);
        w = half_word(1'b0, 0, 32);
        n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL i2s_leadin: got %h expected 00000000", w); end
        w = half_word(1'b0, 1, 32);
        n_vec++; if (w !== {1'b0, 16'hA5C3, 15'h0}) begin n_err++; $display("FAIL i2s_left: got %h expected %h", w, {1'b0, 16'hA5C3, 15'h0}); end
        w = half_word(1'b0, 2, 32);
        n_vec++; if (w !== {1'b0, 16'h0F0F, 15'h0}) begin n_err++; $display("FAIL i2s_right: got %h expected %h", w, {1'b0, 16'h0F0F, 15'h0}); end
        n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL i2s_ready_after_load: got %b expected 1", ready0); end
    endtask

    task automatic test_lj();
        logic [31:0] w;
        do_reset();
        en = 1'b1;
        pq.push_back({16'hA5C3, 16'h0F0F});
        repeat (4) @(posedge clk); #1;
        play(3, 32, -1, 32'h0);
        w = half_word(1'b1, 1, 32);
        n_vec++; if (w !== {16'hA5C3, 16'h0}) begin n_err++; $display("FAIL lj_left: got %h expected %h", w, {16'hA5C3, 16'h0}); end
        w = half_word(1'b1, 2, 32);
        n_vec++; if (w !== {16'h0F0F, 16'h0}) begin n_err++; $display("FAIL lj_right: got %h expected %h", w, {16'h0F0F, 16'h0}); end
    endtask

    task automatic test_underflow();
        logic [31:0] w;
        int b0, b1;
        do_reset();
        en = 1'b1;
        b0 = uf_cnt0; b1 = uf_cnt1;
        play(5, 32, -1, 32'h0);
        w = half_word(1'b0, 1, 32) | half_word(1'b0, 2, 32) | half_word(1'b0, 3, 32) | half_word(1'b0, 4, 32);
        n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL uf_data0: got %h expected 00000000", w); end
        w = half_word(1'b1, 1, 32) | half_word(1'b1, 2, 32) | half_word(1'b1, 3, 32) | half_word(1'b1, 4, 32);
        n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL uf_data1: got %h expected 00000000", w); end
        n_vec++; if (uf_cnt0 - b0 !== 2) begin n_err++; $display("FAIL uf_pulses0: got %0d expected 2", uf_cnt0 - b0); end
        n_vec++; if (uf_cnt1 - b1 !== 2) begin n_err++; $display("FAIL uf_pulses1: got %0d expected 2", uf_cnt1 - b1); end

        // Disabled: no pulse, zeros out, buffered frame stays for later.
        do_reset();
        en = 1'b0;
        b0 = uf_cnt0;
        pq.push_back({16'h1234, 16'h5678});
        repeat (4) @(posedge clk); #1;
        play(5, 32, -1, 32'h0);
        w = half_word(1'b0, 1, 32) | half_word(1'b0, 2, 32) | half_word(1'b0, 3, 32) | half_word(1'b0, 4, 32);
        n_vec++; if (w !== 32'h0) begin n_err++; $display("FAIL dis_data: got %h expected 00000000", w); end
        n_vec++; if (uf_cnt0 - b0 !== 0) begin n_err++; $display("FAIL dis_pulses: got %0d expected 0", uf_cnt0 - b0); end
        n_vec++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL dis_buffer_kept: got %b expected 0", ready0); end
        en = 1'b1;
        play(3, 32, -1, 32'h0);
        w = half_word(1'b0, 1, 32);
        n_vec++; if (w !== {1'b0, 16'h1234, 15'h0}) begin n_err++; $display("FAIL reen_left: got %h expected %h", w, {1'b0, 16'h1234, 15'h0}); end
        n_vec++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL reen_ready: got %b expected 1", ready0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int a0;
        do_reset();
        en = 1'b1;
        a0 = acc_cnt;
        pq.push_back({16'h1111, 16'h2222});
        pq.push_back({16'h3333, 16'h4444});
        repeat (6) @(posedge clk); #1;
        n_vec++; if (acc_cnt - a0 !== 1) begin n_err++; $display("FAIL b2b_held: got %0d accepts expected 1", acc_cnt - a0); end
        n_vec++; if (ready0 !== 1'b0) begin n_err++; $display("FAIL b2b_ready: got %b expected 0", ready0); end
        play(5, 32, -1, 32'h0);
        w = half_word(1'b0, 1, 32);
        n_vec++; if (w !== {1'b0, 16'h1111, 15'h0}) begin n_err++; $display("FAIL b2b_f1_left: got %h expected %h", w, {1'b0, 16'h1111, 15'h0}); end
        w = half_word(1'b0, 2, 32);
        n_vec++; if (w !== {1'b0, 16'h2222, 15'h0}) begin n_err++; $display("FAIL b2b_f1_right: got %h expected %h", w, {1'b0, 16'h2222, 15'h0}); end
        w = half_word(1'b0, 3, 32);
        n_vec++; if (w !== {1'b0, 16'h3333, 15'h0}) begin n_err++; $display("FAIL b2b_f2_left: got %h expected %h", w, {1'b0, 16'h3333, 15'h0}); end
        w = half_word(1'b0, 4, 32);
        n_vec++; if (w !== {1'b0, 16'h4444, 15'h0}) begin n_err++; $display("FAIL b2b_f2_right: got %h expected %h", w, {1'b0, 16'h4444, 15'h0}); end
        n_vec++; if (acc_cnt - a0 !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt - a0); end
        n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", busy0); end
    endtask

    task automatic test_short_reset();
        logic [31:0] w;
        int b1;
        do_reset();
        en = 1'b1;
        b1 = uf_cnt1;
        pq.push_back({16'hA5C3, 16'h0F0F});
        repeat (4) @(posedge clk); #1;
        // Reset lands just after bit 5 of the first right half (a 1 on the line).
        play(5, 8, 21, {16'h1234, 16'h5678});
        w = half_word(1'b1, 1, 8);
        n_vec++; if (w !== 32'hA5) begin n_err++; $display("FAIL short_left: got %h expected 000000a5", w); end
        w = half_word(1'b1, 2, 8);
        n_vec++; if (w !== 32'h0C) begin n_err++; $display("FAIL short_right_reset: got %h expected 0000000c", w); end
        n_vec++; if (rst_dac1 !== 1'b0) begin n_err++; $display("FAIL midrst_dac: got %b expected 0", rst_dac1); end
        n_vec++; if (rst_busy1 !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", rst_busy1); end
        n_vec++; if (rst_ready1 !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", rst_ready1); end
        w = half_word(1'b1, 3, 8);
        n_vec++; if (w !== 32'h12) begin n_err++; $display("FAIL resume_left: got %h expected 00000012", w); end
        w = half_word(1'b1, 4, 8);
        n_vec++; if (w !== 32'h56) begin n_err++; $display("FAIL resume_right: got %h expected 00000056", w); end
        n_vec++; if (uf_cnt1 - b1 !== 0) begin n_err++; $display("FAIL short_pulses: got %0d expected 0", uf_cnt1 - b1); end
    endtask

    initial begin : main
        rst  = 1'b1;
        bclk = 1'b0;
        lrck = 1'b0;
        en   = 1'b1;
        test_reset();
        test_i2s();
        test_lj();
        test_underflow();
        test_back_to_back();
        test_short_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
